pla_or_plane_loader: RTL and testbench



---
 rtl/pla_pkg.sv | 21 ++
 rtl/pla_or_plane_loader.sv | 98 +++++++++
 tb/tb_pla_or_plane_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pla_pkg.sv
// Shared PLA definitions: loader FSM states, default plane dimensions and a one-hot decode.
package pla_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      SETUP  = 3'd2,
      STROBE = 3'd3,
      HOLD   = 3'd4
   } load_state_t;

   localparam int PLA_NUM_INPUTS  = 5;
   localparam int PLA_NUM_OUTPUTS = 4;
   localparam int PLA_ONEHOT_W    = 32;

   // Wide one-hot; callers size-cast the result down to their strobe width.
   function automatic logic [PLA_ONEHOT_W-1:0] onehot(input logic [31:0] k);
      return PLA_ONEHOT_W'(1) << k;
   endfunction

endpackage

// File: rtl/pla_or_plane_loader.sv
// Programs OR-plane cells one at a time: sel is set up a cycle before and held a cycle
// after each single-cycle wen pulse, so each cell captures a settled select word.
module pla_or_plane_loader
   import pla_pkg::*;
#(
   parameter int NUM_INPUTS  = PLA_NUM_INPUTS,
   parameter int NUM_OUTPUTS = PLA_NUM_OUTPUTS,
   parameter int IDX_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   cfg_valid,
   input  logic [NUM_INPUTS-1:0]  cfg_data,
   output logic                   cfg_ready,
   output logic [NUM_INPUTS-1:0]  sel,
   output logic [NUM_OUTPUTS-1:0] wen,
   output logic                   busy,
   output logic                   done,
   output logic [IDX_W-1:0]       idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUTS - 1);

   load_state_t            state, state_nxt;
   logic [NUM_INPUTS-1:0]  sel_nxt;
   logic [NUM_OUTPUTS-1:0] wen_nxt;
   logic [IDX_W-1:0]       idx_nxt;
   logic                   done_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sel   <= '0;
         wen   <= '0;
         idx   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         wen   <= wen_nxt;
         idx   <= idx_nxt;
         done  <= done_nxt;
      end
   end

   // wen defaults low every cycle, so a strobe can never last more than one cycle.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      wen_nxt   = '0;
      idx_nxt   = idx;
      done_nxt  = done;
      if (state != IDLE && abort) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  state_nxt = WAIT;
                  idx_nxt   = '0;
                  done_nxt  = 1'b0;
               end
            end
            WAIT: begin
               if (cfg_valid) begin
                  sel_nxt   = cfg_data;
                  state_nxt = SETUP;
               end
            end
            SETUP: begin
               state_nxt = STROBE;
               wen_nxt   = NUM_OUTPUTS'(onehot(32'(idx)));
            end
            STROBE: state_nxt = HOLD;
            HOLD: begin
               if (idx == LAST_IDX) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  idx_nxt   = idx + IDX_W'(1);
                  state_nxt = WAIT;
               end
            end
            default: begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign cfg_ready = (state == WAIT);

endmodule

// File: tb/tb_pla_or_plane_loader.sv
// Directed bench for the OR-plane loader: expected values are hand-derived constants.
module tb_pla_or_plane_loader;

   logic       clk = 1'b0;
   logic       rst, start, abort, cfg_valid;
   logic [4:0] cfg_data;
   logic       cfg_ready, busy, done;
   logic [4:0] sel;
   logic [3:0] wen;
   logic [1:0] idx;

   int total = 0;
   int bad   = 0;

   logic [4:0] words [4] = '{5'h03, 5'h1F, 5'h00, 5'h15};

   pla_or_plane_loader dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .sel(sel), .wen(wen), .busy(busy), .done(done), .idx(idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 5'h0A;
      tick(); tick();
      total++; if (sel !== 5'h00) begin bad++; $display("FAIL reset_sel got=%h want=00", sel); end
      total++; if (wen !== 4'b0000) begin bad++; $display("FAIL reset_wen got=%b want=0000", wen); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", cfg_ready); end
      total++; if (idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", idx); end
      rst = 1'b0; cfg_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (wen !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL idle_quiet wen=%b busy=%b want 0000/0", wen, busy); end
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_full_load();
      int cyc;
      start = 1'b1; cfg_valid = 1'b1; cfg_data = words[0];
      tick();
      start = 1'b0; cyc = 0;
      total++; if (busy !== 1'b1 || cfg_ready !== 1'b1 || idx !== 2'd0) begin bad++; $display("FAIL load_wait0 busy=%b ready=%b idx=%0d want 1/1/0", busy, cfg_ready, idx); end
      for (int k = 0; k < 4; k++) begin
         cfg_data = words[k];
         tick(); cyc++;
         cfg_data = 5'h0A;
         total++; if (sel !== words[k] || wen !== 4'b0000 || cfg_ready !== 1'b0) begin bad++; $display("FAIL load_setup%0d sel=%h wen=%b ready=%b want %h/0000/0", k, sel, wen, cfg_ready, words[k]); end
         tick(); cyc++;
         total++; if (wen !== (4'b0001 << k) || sel !== words[k] || idx !== 2'(k)) begin bad++; $display("FAIL load_strobe%0d wen=%b sel=%h idx=%0d want %b/%h/%0d", k, wen, sel, idx, 4'b0001 << k, words[k], k); end
         tick(); cyc++;
         total++; if (wen !== 4'b0000 || sel !== words[k] || done !== 1'b0) begin bad++; $display("FAIL load_hold%0d wen=%b sel=%h done=%b want 0000/%h/0", k, wen, sel, done, words[k]); end
         tick(); cyc++;
      end
      cfg_valid = 1'b0;
      total++; if (done !== 1'b1 || busy !== 1'b0 || cyc != 16) begin bad++; $display("FAIL load_done done=%b busy=%b cycles=%0d want 1/0/16", done, busy, cyc); end
      total++; if (sel !== 5'h15 || idx !== 2'd3) begin bad++; $display("FAIL load_persist sel=%h idx=%0d want 15/3", sel, idx); end
   endtask

   task automatic test_start_ignored();
      start = 1'b1; abort = 1'b1;
      tick();
      abort = 1'b0;
      total++; if (busy !== 1'b0 || done !== 1'b1 || idx !== 2'd3) begin bad++; $display("FAIL startabort_idle busy=%b done=%b idx=%0d want 0/1/3", busy, done, idx); end
      tick();
      start = 1'b0;
      total++; if (busy !== 1'b1 || done !== 1'b0 || idx !== 2'd0) begin bad++; $display("FAIL restart busy=%b done=%b idx=%0d want 1/0/0", busy, done, idx); end
      start = 1'b1;
      tick();
      total++; if (cfg_ready !== 1'b1 || idx !== 2'd0 || done !== 1'b0) begin bad++; $display("FAIL start_in_wait ready=%b idx=%0d done=%b want 1/0/0", cfg_ready, idx, done); end
      cfg_valid = 1'b1; cfg_data = 5'h09;
      tick();
      cfg_valid = 1'b0;
      total++; if (sel !== 5'h09 || cfg_ready !== 1'b0 || wen !== 4'b0000) begin bad++; $display("FAIL start_setup sel=%h ready=%b wen=%b want 09/0/0000", sel, cfg_ready, wen); end
      tick();
      start = 1'b0;
      total++; if (wen !== 4'b0001 || idx !== 2'd0) begin bad++; $display("FAIL start_in_setup wen=%b idx=%0d want 0001/0", wen, idx); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_gapped();
      start = 1'b1; cfg_valid = 1'b1; cfg_data = words[0];
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cfg_data = words[k];
         if (k == 1) begin
            cfg_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
               tick();
               total++; if (cfg_ready !== 1'b1 || wen !== 4'b0000 || sel !== 5'h03 || idx !== 2'd1) begin bad++; $display("FAIL gap_wait%0d ready=%b wen=%b sel=%h idx=%0d want 1/0000/03/1", g, cfg_ready, wen, sel, idx); end
            end
            cfg_valid = 1'b1;
         end
         tick(); tick();
         total++; if (wen !== (4'b0001 << k) || sel !== words[k]) begin bad++; $display("FAIL gap_strobe%0d wen=%b sel=%h want %b/%h", k, wen, sel, 4'b0001 << k, words[k]); end
         tick(); tick();
      end
      cfg_valid = 1'b0;
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL gap_done done=%b busy=%b want 1/0", done, busy); end
   endtask

   task automatic test_abort();
      start = 1'b1; cfg_valid = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cfg_data = words[k];
         tick(); tick(); tick(); tick();
      end
      cfg_data = words[2];
      tick(); tick();
      total++; if (wen !== 4'b0100 || idx !== 2'd2) begin bad++; $display("FAIL abort_pre wen=%b idx=%0d want 0100/2", wen, idx); end
      abort = 1'b1;
      tick();
      abort = 1'b0; cfg_valid = 1'b0;
      total++; if (wen !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || idx !== 2'd0 || cfg_ready !== 1'b0) begin bad++; $display("FAIL abort_strobe wen=%b busy=%b done=%b idx=%0d ready=%b want 0000/0/0/0/0", wen, busy, done, idx, cfg_ready); end
      start = 1'b1;
      tick();
      start = 1'b0; cfg_valid = 1'b1; cfg_data = 5'h1B; abort = 1'b1;
      tick();
      abort = 1'b0; cfg_valid = 1'b0;
      total++; if (sel !== 5'h00 || busy !== 1'b0) begin bad++; $display("FAIL abort_word sel=%h busy=%b want 00/0", sel, busy); end
      start = 1'b1;
      tick();
      start = 1'b0; cfg_valid = 1'b1; cfg_data = 5'h07;
      tick();
      cfg_valid = 1'b0;
      tick();
      total++; if (wen !== 4'b0001 || sel !== 5'h07 || idx !== 2'd0) begin bad++; $display("FAIL abort_reload wen=%b sel=%h idx=%0d want 0001/07/0", wen, sel, idx); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_rst_hold();
      start = 1'b1; cfg_valid = 1'b1; cfg_data = words[0];
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      cfg_data = words[1];
      tick(); tick(); tick();
      total++; if (idx !== 2'd1 || wen !== 4'b0000 || busy !== 1'b1 || sel !== 5'h1F) begin bad++; $display("FAIL rst_pre idx=%0d wen=%b busy=%b sel=%h want 1/0000/1/1F", idx, wen, busy, sel); end
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
      total++; if (sel !== 5'h00 || wen !== 4'b0000 || idx !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_hold sel=%h wen=%b idx=%0d busy=%b done=%b ready=%b want all 0", sel, wen, idx, busy, done, cfg_ready); end
      start = 1'b1;
      tick();
      start = 1'b0; cfg_valid = 1'b1; cfg_data = 5'h11;
      tick();
      cfg_valid = 1'b0;
      tick();
      total++; if (wen !== 4'b0001 || sel !== 5'h11) begin bad++; $display("FAIL rst_reload wen=%b sel=%h want 0001/11", wen, sel); end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_start_ignored();
      test_gapped();
      test_abort();
      test_rst_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
